// File: rtl/pcomp_trigger.sv
// Position-compare trigger: emits a pulse train at START, START+STEP, ... on the counter position,
// each pulse WIDTH position units wide, for either counting direction.
module pcomp_trigger #(
    parameter int unsigned DW = 32,
    parameter int unsigned CW = 32
) (
    input  logic          clk_i,
    input  logic          reset_n_i,
    input  logic          enable_i,
    input  logic [DW-1:0] posn_i,
    input  logic          DIR,
    input  logic [DW-1:0] START,
    input  logic [DW-1:0] STEP,
    input  logic [DW-1:0] WIDTH,
    input  logic [CW-1:0] PNUM,
    output logic          pulse_o,
    output logic          active_o,
    output logic          err_o,
    output logic [CW-1:0] count_o
);

    // Two guard bits keep point +/- STEP and point +/- WIDTH exact for range checks.
    localparam int unsigned EW = DW + 2;
    localparam logic signed [EW-1:0] PosMax = {3'b000, {(DW-1){1'b1}}};
    localparam logic signed [EW-1:0] PosMin = {3'b111, {(DW-1){1'b0}}};
    localparam logic [CW-1:0] CntOne = {{(CW-1){1'b0}}, 1'b1};

    localparam logic [2:0] StIdle     = 3'd0;
    localparam logic [2:0] StWaitPre  = 3'd1;
    localparam logic [2:0] StWaitRise = 3'd2;
    localparam logic [2:0] StWaitFall = 3'd3;
    localparam logic [2:0] StDone     = 3'd4;
    localparam logic [2:0] StError    = 3'd5;

    logic [2:0]           state_q, state_d;
    logic                 en_q;
    logic                 dir_q;
    logic [DW-1:0]        step_q, width_q;
    logic [CW-1:0]        pnum_q;
    logic signed [DW:0]   point_q, point_d;
    logic                 pulse_q, pulse_d;
    logic                 active_q, active_d;
    logic                 err_q, err_d;
    logic [CW-1:0]        count_q, count_d;
    logic                 cfg_latch;

    logic signed [EW-1:0] posn_x, point_x, next_pt, edge_pt;
    logic                 en_rise, cfg_bad, next_oor, pre_side;

    function automatic logic reached(input logic dir, input logic signed [EW-1:0] posn,
                                     input logic signed [EW-1:0] x);
        return dir ? (posn <= x) : (posn >= x);
    endfunction

    always_comb begin
        posn_x   = {{2{posn_i[DW-1]}}, posn_i};
        point_x  = {point_q[DW], point_q};
        next_pt  = dir_q ? point_x - {2'b00, step_q}  : point_x + {2'b00, step_q};
        edge_pt  = dir_q ? point_x - {2'b00, width_q} : point_x + {2'b00, width_q};
        next_oor = (next_pt > PosMax) || (next_pt < PosMin);
        pre_side = dir_q ? (posn_x > point_x) : (posn_x < point_x);
        en_rise  = enable_i & ~en_q;
        cfg_bad  = (STEP == '0) || (WIDTH == '0) || (WIDTH >= STEP);
    end

    always_comb begin
        state_d   = state_q;
        pulse_d   = pulse_q;
        active_d  = active_q;
        err_d     = err_q;
        count_d   = count_q;
        point_d   = point_q;
        cfg_latch = 1'b0;
        unique case (state_q)
            StIdle: begin
                pulse_d  = 1'b0;
                active_d = 1'b0;
                if (en_rise) begin
                    cfg_latch = 1'b1;
                    point_d   = {START[DW-1], START};
                    if (cfg_bad) begin
                        state_d = StError;
                        err_d   = 1'b1;
                    end else begin
                        state_d  = StWaitPre;
                        active_d = 1'b1;
                        count_d  = '0;
                        err_d    = 1'b0;
                    end
                end
            end
            StWaitPre, StWaitRise, StWaitFall: begin
                if (!enable_i) begin
                    state_d  = StIdle;
                    pulse_d  = 1'b0;
                    active_d = 1'b0;
                end else if (state_q == StWaitPre) begin
                    if (pre_side) state_d = StWaitRise;
                end else if (state_q == StWaitRise) begin
                    if (reached(dir_q, posn_x, point_x)) begin
                        pulse_d = 1'b1;
                        count_d = count_q + CntOne;
                        state_d = StWaitFall;
                    end
                end else if (reached(dir_q, posn_x, edge_pt)) begin
                    pulse_d = 1'b0;
                    // Edge and the following point seen together: that point was skipped.
                    if (!next_oor && reached(dir_q, posn_x, next_pt)) begin
                        err_d    = 1'b1;
                        active_d = 1'b0;
                        state_d  = StError;
                    end else begin
                        point_d = next_pt[DW:0];
                        if ((pnum_q != '0 && count_q == pnum_q) || next_oor) begin
                            active_d = 1'b0;
                            state_d  = StDone;
                        end else begin
                            state_d = StWaitRise;
                        end
                    end
                end
            end
            StDone, StError: begin
                pulse_d  = 1'b0;
                active_d = 1'b0;
                if (!enable_i) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q  <= StIdle;
            en_q     <= 1'b0;
            pulse_q  <= 1'b0;
            active_q <= 1'b0;
            err_q    <= 1'b0;
            count_q  <= '0;
            point_q  <= '0;
        end else begin
            state_q  <= state_d;
            en_q     <= enable_i;
            pulse_q  <= pulse_d;
            active_q <= active_d;
            err_q    <= err_d;
            count_q  <= count_d;
            point_q  <= point_d;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            dir_q   <= 1'b0;
            step_q  <= '0;
            width_q <= '0;
            pnum_q  <= '0;
        end else if (cfg_latch) begin
            dir_q   <= DIR;
            step_q  <= STEP;
            width_q <= WIDTH;
            pnum_q  <= PNUM;
        end
    end

    assign pulse_o  = pulse_q;
    assign active_o = active_q;
    assign err_o    = err_q;
    assign count_o  = count_q;

endmodule

// File: tb/tb_pcomp_trigger.sv
// Directed bench for pcomp_trigger: vector tables for short scenarios, ramps for full runs.
module tb_pcomp_trigger;

    logic        clk_i = 1'b0;
    logic        reset_n_i = 1'b0;
    logic        enable_i = 1'b0;
    logic [31:0] posn_i = '0;
    logic        DIR = 1'b0;
    logic [31:0] START = '0;
    logic [31:0] STEP = '0;
    logic [31:0] WIDTH = '0;
    logic [31:0] PNUM = '0;
    logic        pulse_o, active_o, err_o;
    logic [31:0] count_o;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic en;
        int   posn;
        logic pulse;
        logic active;
        logic err;
        int   count;
    } vec_t;

    vec_t vq[$];

    pcomp_trigger #(.DW(32), .CW(32)) dut (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .enable_i  (enable_i),
        .posn_i    (posn_i),
        .DIR       (DIR),
        .START     (START),
        .STEP      (STEP),
        .WIDTH     (WIDTH),
        .PNUM      (PNUM),
        .pulse_o   (pulse_o),
        .active_o  (active_o),
        .err_o     (err_o),
        .count_o   (count_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, $signed(got), $signed(exp));
        end
    endtask

    task automatic chk_all(input string tag, input logic p, input logic a, input logic e,
                           input int c);
        chk({tag, ".pulse"}, {31'd0, pulse_o}, {31'd0, p});
        chk({tag, ".active"}, {31'd0, active_o}, {31'd0, a});
        chk({tag, ".err"}, {31'd0, err_o}, {31'd0, e});
        chk({tag, ".count"}, count_o, c);
    endtask

    task automatic cyc(input logic en, input int p);
        enable_i = en;
        posn_i   = p;
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        enable_i  = 1'b0;
        reset_n_i = 1'b0;
        #2;
        reset_n_i = 1'b1;
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_cfg(input logic d, input int s, input int st, input int w, input int n);
        DIR = d; START = s; STEP = st; WIDTH = w; PNUM = n;
    endtask

    task automatic add(input logic en, input int p, input logic ep, input logic ea,
                       input logic ee, input int ec);
        vec_t v;
        v.en = en; v.posn = p; v.pulse = ep; v.active = ea; v.err = ee; v.count = ec;
        vq.push_back(v);
    endtask

    task automatic run_vecs(input string tag);
        foreach (vq[i]) begin
            cyc(vq[i].en, vq[i].posn);
            chk_all($sformatf("%s[%0d]", tag, i), vq[i].pulse, vq[i].active, vq[i].err,
                    vq[i].count);
        end
        vq.delete();
    endtask

    initial begin
        logic ep, ea;
        int   ec;

        // Reset state
        #2;
        chk_all("reset", 1'b0, 1'b0, 1'b0, 0);
        @(posedge clk_i);
        #1;
        reset_n_i = 1'b1;

        // Basic positive run
        set_cfg(1'b0, 100, 50, 10, 3);
        cyc(1'b0, 0);
        chk_all("pos.idle", 1'b0, 1'b0, 1'b0, 0);
        cyc(1'b1, 0);
        chk_all("pos.arm", 1'b0, 1'b1, 1'b0, 0);
        for (int p = 1; p <= 300; p++) begin
            cyc(1'b1, p);
            ep = (p >= 100 && p <= 109) || (p >= 150 && p <= 159) || (p >= 200 && p <= 209);
            ea = (p < 210);
            ec = (p >= 200) ? 3 : (p >= 150) ? 2 : (p >= 100) ? 1 : 0;
            chk($sformatf("pos.pulse@%0d", p), {31'd0, pulse_o}, {31'd0, ep});
            chk($sformatf("pos.active@%0d", p), {31'd0, active_o}, {31'd0, ea});
            chk($sformatf("pos.count@%0d", p), count_o, ec);
        end
        chk("pos.err", {31'd0, err_o}, 32'd0);

        // Negative direction
        do_reset();
        set_cfg(1'b1, -20, 30, 5, 2);
        cyc(1'b1, 0);
        chk_all("neg.arm", 1'b0, 1'b1, 1'b0, 0);
        for (int p = -1; p >= -100; p--) begin
            cyc(1'b1, p);
            ep = (p <= -20 && p >= -24) || (p <= -50 && p >= -54);
            ea = (p > -55);
            ec = (p <= -50) ? 2 : (p <= -20) ? 1 : 0;
            chk($sformatf("neg.pulse@%0d", p), {31'd0, pulse_o}, {31'd0, ep});
            chk($sformatf("neg.active@%0d", p), {31'd0, active_o}, {31'd0, ea});
            chk($sformatf("neg.count@%0d", p), count_o, ec);
        end
        chk("neg.err", {31'd0, err_o}, 32'd0);

        // Armed past start
        do_reset();
        set_cfg(1'b0, 100, 50, 10, 1);
        add(0, 500, 0, 0, 0, 0);
        add(1, 500, 0, 1, 0, 0);
        add(1, 300, 0, 1, 0, 0);
        add(1, 100, 0, 1, 0, 0);
        add(1,  99, 0, 1, 0, 0);
        add(1, 100, 1, 1, 0, 1);
        add(1, 105, 1, 1, 0, 1);
        add(1, 110, 0, 0, 0, 1);
        add(1, 150, 0, 0, 0, 1);
        add(0, 150, 0, 0, 0, 1);
        run_vecs("past");

        // Missed point, err held until re-arm
        do_reset();
        set_cfg(1'b0, 0, 10, 5, 0);
        add(0, -5, 0, 0, 0, 0);
        add(1, -5, 0, 1, 0, 0);
        add(1, -3, 0, 1, 0, 0);
        add(1,  0, 1, 1, 0, 1);
        add(1,  2, 1, 1, 0, 1);
        add(1, 12, 0, 0, 1, 1);
        add(1, 13, 0, 0, 1, 1);
        add(0, 13, 0, 0, 1, 1);
        add(1, -5, 0, 1, 0, 0);
        add(0, -5, 0, 0, 0, 0);
        run_vecs("miss");

        // Bad configuration: WIDTH == STEP
        do_reset();
        set_cfg(1'b0, 0, 10, 10, 0);
        add(0,    0, 0, 0, 0, 0);
        add(1,    0, 0, 0, 1, 0);
        add(1,   10, 0, 0, 1, 0);
        add(1, 1000, 0, 0, 1, 0);
        add(0, 1000, 0, 0, 1, 0);
        run_vecs("bad.eq");

        // Bad configuration: WIDTH == 0
        set_cfg(1'b0, 0, 10, 0, 0);
        add(1,  -1, 0, 0, 1, 0);
        add(1,  50, 0, 0, 1, 0);
        add(0,  50, 0, 0, 1, 0);
        run_vecs("bad.w0");

        // Next point beyond the signed range ends in DONE without error
        do_reset();
        set_cfg(1'b0, 2147483547, 200, 10, 0);
        add(0, 2147483546, 0, 0, 0, 0);
        add(1, 2147483546, 0, 1, 0, 0);
        add(1, 2147483546, 0, 1, 0, 0);
        add(1, 2147483547, 1, 1, 0, 1);
        add(1, 2147483557, 0, 0, 0, 1);
        add(1, 2147483647, 0, 0, 0, 1);
        run_vecs("oor");

        // Single-cycle jump, then abort mid-pulse at count 2
        do_reset();
        set_cfg(1'b0, 0, 100, 10, 0);
        add(0,  -1, 0, 0, 0, 0);
        add(1,  -1, 0, 1, 0, 0);
        add(1,  -1, 0, 1, 0, 0);
        add(1,  50, 1, 1, 0, 1);
        add(1,  50, 0, 1, 0, 1);
        add(1,  60, 0, 1, 0, 1);
        add(1, 100, 1, 1, 0, 2);
        add(0, 100, 0, 0, 0, 2);
        run_vecs("jump");

        // Asynchronous reset clears count without a clock edge
        reset_n_i = 1'b0;
        #2;
        chk("async.count", count_o, 32'd0);
        reset_n_i = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pcomp_trigger.md
Name: pcomp_trigger

Overview:
- Position-compare stage directly downstream of the counter block.
- Consumes the counter's 32-bit position output (posn_i) and emits a train of pulses at programmed positions: START, START+STEP, START+2*STEP, ...
- Each pulse stays high for WIDTH position units.
- pulse_o drives capture/gate logic elsewhere in the design.
- Handles both counting directions, a finite or unbounded pulse count, and reports missed points.

Parameters:
DW, 32, width of posn_i, START, STEP and WIDTH (signed two's complement)
CW, 32, width of PNUM and of the pulse counter

Ports:
clk_i  in  1  system clock
reset_n_i  in  1  asynchronous active-low reset
enable_i  in  1  run gate; a rising edge arms the block, low aborts
posn_i  in  DW  position from counter out_o, signed
DIR  in  1  0 = positive direction, 1 = negative direction
START  in  DW  first compare point, signed
STEP  in  DW  spacing between points, unsigned magnitude, >0
WIDTH  in  DW  pulse width in position units, unsigned, >0
PNUM  in  CW  number of pulses; 0 = unbounded
pulse_o  out  1  compare pulse, registered
active_o  out  1  high while armed and generating
err_o  out  1  sticky error flag
count_o  out  CW  pulses generated since arm

Behaviour:
- Reset: one clock; reset is asynchronous and active-low.
  - Asserting reset_n_i low immediately forces state IDLE.
  - Reset clears pulse_o, active_o, err_o and count_o, all 0.
- All inputs are sampled on the rising edge of clk_i; outputs are registered.
- Configuration latch: DIR, START, STEP, WIDTH and PNUM are latched on the enable_i rising edge, detected as enable_i=1 with previous enable_i=0. Changes while armed are ignored.
- Arithmetic:
  - Compare points are held in DW+1-bit signed registers. point <= point ± STEP, with + for DIR=0 and − for DIR=1.
  - Falling edge position: edge = point ± WIDTH.
  - "Reached X" means posn_i >= X for DIR=0, or posn_i <= X for DIR=1, compared as signed values.
  - If the next point leaves the DW-bit signed range, the sequence ends in DONE with no error.
- States:
  - IDLE: outputs low. On an enable rising edge:
    - if WIDTH=0, STEP=0 or WIDTH>=STEP: go to ERROR with err_o=1;
    - otherwise go to WAIT_PRE with active_o=1, count_o=0 and err_o cleared.
  - WAIT_PRE: wait until posn_i is strictly on the pre-start side of START (posn_i<START for DIR=0, posn_i>START for DIR=1). Prevents firing when armed already past START. Then go to WAIT_RISE.
  - WAIT_RISE: when point is reached:
    - pulse_o=1 on the next edge (1-cycle latency from the posn_i sample);
    - count_o increments;
    - go to WAIT_FALL.
  - WAIT_FALL: when edge is reached:
    - pulse_o=0 and point advances by STEP;
    - if PNUM!=0 and count_o==PNUM, go to DONE, else go to WAIT_RISE.
  - WAIT_FALL miss: if posn_i reaches point±STEP (the next point) in the same cycle the edge is reached, the point was missed. Set err_o=1, pulse_o=0, go to ERROR.
  - DONE: active_o=0, pulse_o=0. Stay until enable_i goes low, then go to IDLE.
  - ERROR: active_o=0, pulse_o=0, err_o held. Leave for IDLE when enable_i goes low.
- Abort: enable_i=0 in any armed state returns the block to IDLE next cycle.
  - pulse_o and active_o drop on that edge.
  - count_o and err_o hold their values until the next arm.
- Single-cycle jump: if posn_i jumps past both point and edge in one sample, WAIT_RISE still emits a one-cycle pulse. The edge is then evaluated in WAIT_FALL on the following cycle.
- Simultaneous events: an enable_i rising edge together with a reset has no effect; reset dominates.

Test Plan:
- Basic positive run: DIR=0, START=100, STEP=50, WIDTH=10, PNUM=3; posn ramps 0..300 by 1/cycle.
  -> pulse_o high for posn 100..109, 150..159 and 200..209, each rising 1 cycle after the matching sample.
  -> count_o=3, then active_o=0 (DONE).
- Negative direction: DIR=1, START=-20, STEP=30, WIDTH=5, PNUM=2; posn ramps 0 down to -100.
  -> pulses at -20..-24 and -50..-54.
  -> count_o=2, err_o=0.
- Armed past start: posn=500 at arm, START=100, DIR=0.
  -> no pulse until posn drops below 100 and then reaches 100 again.
- Missed point: START=0, STEP=10, WIDTH=5; after the first rise, posn jumps from 2 to 12.
  -> err_o=1, pulse_o=0, active_o=0.
  -> err_o holds until the next arm.
- Bad configuration: WIDTH=10, STEP=10 at arm.
  -> err_o=1 next cycle; pulse_o never asserts.
- Abort mid-pulse: enable_i low while pulse_o=1 at count_o=2, PNUM=0.
  -> pulse_o=0 and active_o=0 next cycle; count_o stays 2.
  -> Asserting reset_n_i low asynchronously clears count_o to 0 without waiting for a clock edge.
